// File: rtl/flow_ctrl_pkg.sv
// flow_ctrl_pkg: state encoding and constants shared by clocked async-fabric initiators
package flow_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, REQ, WAIT_FIN, CLR, WAIT_CLR, GAP} state_t;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: single-bit flop-chain synchroniser for an asynchronous level input
module sync_2ff
  import flow_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic [SYNC_STAGES-1:0] r_sync;
  // Shift the async level through the chain; the last stage is safe to use
  always_ff @(posedge clk or posedge rst)
    if (rst) r_sync <= '0;
    else r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  assign o_q = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/function_dispatcher.sv
// function_dispatcher: clocked initiator driving one-hot requests and the clear line of an async function chooser
module function_dispatcher
  import flow_ctrl_pkg::*;
#(
  parameter int N           = 2,
  parameter int SEL_W       = $clog2(N),
  parameter int TIMEOUT     = 255,
  parameter int CLR_LOW_MIN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SEL_W-1:0] sel,
  output logic [N-1:0]     reqs,
  output logic             chooser_rst,
  input  logic             fin,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [SEL_W-1:0] last_sel
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CLR_LOW_MIN - 1);
  state_t           r_state, w_state_nxt;
  logic [N-1:0]     r_reqs, w_reqs_nxt, w_onehot;
  logic             r_crst, w_crst_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err, w_err_nxt;
  logic             r_abort, w_abort_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [SEL_W-1:0] r_last, w_last_nxt;
  logic             w_fin_s, w_sel_ok;
  sync_2ff u_fin_sync (
    .clk (clk),
    .rst (rst),
    .i_d (fin),
    .o_q (w_fin_s)
  );
  assign w_sel_ok = {1'b0, sel} < (SEL_W + 1)'(N);
  assign w_onehot = {{(N-1){1'b0}}, 1'b1} << sel;
  // Next-state and next-output logic; every output is registered so request lines never glitch
  always_comb begin
    w_state_nxt = r_state;
    w_reqs_nxt  = r_reqs;
    w_crst_nxt  = r_crst;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_abort_nxt = r_abort;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    unique case (r_state)
      IDLE:
        if (start && w_sel_ok) begin
          w_last_nxt  = sel;
          w_reqs_nxt  = w_onehot;
          w_state_nxt = REQ;
        end else if (start) w_err_nxt = 1'b1;
      REQ: begin
        w_cnt_nxt   = '0;
        w_state_nxt = WAIT_FIN;
      end
      WAIT_FIN:
        if (w_fin_s || r_cnt == TO_LAST) begin
          w_reqs_nxt  = '0;
          w_crst_nxt  = 1'b1;
          w_abort_nxt = !w_fin_s;
          w_state_nxt = CLR;
        end else w_cnt_nxt = r_cnt + 1'b1;
      CLR: begin
        w_cnt_nxt   = '0;
        w_state_nxt = WAIT_CLR;
      end
      WAIT_CLR:
        if (!w_fin_s || r_cnt == TO_LAST) begin
          w_crst_nxt  = 1'b0;
          w_abort_nxt = r_abort | w_fin_s;
          w_cnt_nxt   = '0;
          w_state_nxt = GAP;
        end else w_cnt_nxt = r_cnt + 1'b1;
      GAP:
        if (r_cnt == GAP_LAST) begin
          w_done_nxt  = !r_abort;
          w_err_nxt   = r_abort;
          w_abort_nxt = 1'b0;
          w_state_nxt = IDLE;
        end else w_cnt_nxt = r_cnt + 1'b1;
      default: w_state_nxt = IDLE;
    endcase
  end
  // State and output registers; reset clears everything immediately
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_reqs  <= '0;
      r_crst  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_abort <= 1'b0;
      r_cnt   <= '0;
      r_last  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_reqs  <= w_reqs_nxt;
      r_crst  <= w_crst_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_abort <= w_abort_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
    end
  assign reqs        = r_reqs;
  assign chooser_rst = r_crst;
  assign busy        = r_state != IDLE;
  assign done        = r_done;
  assign err         = r_err;
  assign last_sel    = r_last;
endmodule

// File: tb/tb_function_dispatcher.sv
// tb_function_dispatcher: scoreboard bench with a behavioural chooser model
module tb_function_dispatcher;
  localparam int N = 3, SEL_W = 2, TIMEOUT = 8, CLR_LOW_MIN = 2;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, chooser_en = 1'b1, r_fin = 1'b0;
  logic [SEL_W-1:0] sel = '0, last_sel, model_last = '0;
  logic [N-1:0] reqs;
  logic fin, chooser_rst, busy, done, err;
  int checks = 0, errors = 0;
  typedef struct packed { logic is_err; logic [SEL_W-1:0] sel; } exp_t;
  exp_t exp_q[$];
  exp_t e;

  function_dispatcher #(.N(N), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT), .CLR_LOW_MIN(CLR_LOW_MIN)) dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel), .reqs(reqs), .chooser_rst(chooser_rst),
    .fin(fin), .busy(busy), .done(done), .err(err), .last_sel(last_sel)
  );

  always #5 clk = ~clk;

  // Chooser: fin rises the cycle after any request, falls the cycle after clear
  always @(posedge clk)
    if (!chooser_en || chooser_rst) r_fin <= 1'b0;
    else if (|reqs) r_fin <= 1'b1;
  assign fin = r_fin;

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (reqs !== '0 || chooser_rst !== 1'b0) begin errors++; $display("FAIL reset_lines: got reqs=%b crst=%b want 000 0", reqs, chooser_rst); end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_status: got busy=%b done=%b err=%b want 0 0 0", busy, done, err); end
    checks++;
    if (last_sel !== '0) begin errors++; $display("FAIL reset_last_sel: got %0d want 0", last_sel); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_normal;
    @(posedge clk); #1 start = 1'b1; sel = 2'd2; model_last = 2'd2;
    exp_q.push_back('{is_err: 1'b0, sel: 2'd2});
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      checks++;
      if (reqs !== ((k <= 4) ? 3'b100 : 3'b000)) begin errors++; $display("FAIL normal_reqs c%0d: got %b want %b", k, reqs, (k <= 4) ? 3'b100 : 3'b000); end
      checks++;
      if (chooser_rst !== (k >= 5 && k <= 8)) begin errors++; $display("FAIL normal_crst c%0d: got %b want %b", k, chooser_rst, k >= 5 && k <= 8); end
      checks++;
      if (done !== (k == 11) || err !== 1'b0) begin errors++; $display("FAIL normal_pulse c%0d: got done=%b err=%b want done=%b err=0", k, done, err, k == 11); end
      if (done || err) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL normal_unexpected: got done=%b err=%b want none", done, err); end
        else begin
          e = exp_q.pop_front();
          if (err !== e.is_err || done !== !e.is_err || last_sel !== e.sel) begin errors++; $display("FAIL normal_result: got err=%b last_sel=%0d want err=%b last_sel=%0d", err, last_sel, e.is_err, e.sel); end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL normal_outstanding: got %0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_bad_index;
    @(posedge clk); #1 start = 1'b1; sel = 2'd3;
    exp_q.push_back('{is_err: 1'b1, sel: model_last});
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || reqs !== '0) begin errors++; $display("FAIL bad_idle c%0d: got busy=%b reqs=%b want 0 000", k, busy, reqs); end
      checks++;
      if (err !== (k == 1) || done !== 1'b0) begin errors++; $display("FAIL bad_err c%0d: got err=%b done=%b want err=%b done=0", k, err, done, k == 1); end
      if (done || err) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL bad_unexpected: got done=%b err=%b want none", done, err); end
        else begin
          e = exp_q.pop_front();
          if (err !== e.is_err || done !== !e.is_err || last_sel !== e.sel) begin errors++; $display("FAIL bad_result: got err=%b last_sel=%0d want err=%b last_sel=%0d", err, last_sel, e.is_err, e.sel); end
        end
      end
      @(posedge clk); #1 start = 1'b0;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL bad_outstanding: got %0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_timeout;
    chooser_en = 1'b0;
    @(posedge clk); #1 start = 1'b1; sel = 2'd1; model_last = 2'd1;
    exp_q.push_back('{is_err: 1'b1, sel: 2'd1});
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checks++;
      if (reqs !== ((k <= 9) ? 3'b010 : 3'b000)) begin errors++; $display("FAIL to_reqs c%0d: got %b want %b", k, reqs, (k <= 9) ? 3'b010 : 3'b000); end
      checks++;
      if (chooser_rst !== (k == 10 || k == 11)) begin errors++; $display("FAIL to_crst c%0d: got %b want %b", k, chooser_rst, k == 10 || k == 11); end
      checks++;
      if (err !== (k == 14) || done !== 1'b0) begin errors++; $display("FAIL to_pulse c%0d: got err=%b done=%b want err=%b done=0", k, err, done, k == 14); end
      if (done || err) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL to_unexpected: got done=%b err=%b want none", done, err); end
        else begin
          e = exp_q.pop_front();
          if (err !== e.is_err || done !== !e.is_err || last_sel !== e.sel) begin errors++; $display("FAIL to_result: got err=%b last_sel=%0d want err=%b last_sel=%0d", err, last_sel, e.is_err, e.sel); end
        end
      end
    end
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin errors++; $display("FAIL to_idle: got busy=%b pending=%0d want 0 0", busy, exp_q.size()); exp_q.delete(); end
    chooser_en = 1'b1;
  endtask

  task automatic test_busy_ignore;
    int n_done;
    n_done = 0;
    @(posedge clk); #1 start = 1'b1; sel = 2'd0; model_last = 2'd0;
    exp_q.push_back('{is_err: 1'b0, sel: 2'd0});
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      checks++;
      if ((reqs & 3'b110) !== 3'b000) begin errors++; $display("FAIL busy_reqs c%0d: got %b want only bit0", k, reqs); end
      if (done) n_done++;
      if (done || err) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL busy_unexpected: got done=%b err=%b want none", done, err); end
        else begin
          e = exp_q.pop_front();
          if (err !== e.is_err || done !== !e.is_err || last_sel !== e.sel) begin errors++; $display("FAIL busy_result: got err=%b last_sel=%0d want err=%b last_sel=%0d", err, last_sel, e.is_err, e.sel); end
        end
      end
      @(posedge clk); #1 start = (k == 2); sel = 2'd1;
    end
    checks++;
    if (n_done != 1 || last_sel !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL busy_final: got dones=%0d last_sel=%0d busy=%b want 1 0 0", n_done, last_sel, busy); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back;
    logic kick, had_high, prev_crst;
    logic [SEL_W-1:0] ksel;
    int n_done, low_run, min_gap;
    kick = 1'b1; ksel = 2'd0; had_high = 1'b0; prev_crst = 1'b0;
    n_done = 0; low_run = 0; min_gap = 1000;
    for (int k = 0; k < 60 && n_done < 2; k++) begin
      @(posedge clk); #1;
      start = kick;
      if (kick) begin sel = ksel; model_last = ksel; exp_q.push_back('{is_err: 1'b0, sel: ksel}); end
      kick = 1'b0;
      @(negedge clk);
      checks++;
      if ((|reqs && chooser_rst) || (done && err) || !$onehot0(reqs)) begin errors++; $display("FAIL b2b_invariant: got reqs=%b crst=%b done=%b err=%b", reqs, chooser_rst, done, err); end
      if (chooser_rst && !prev_crst && had_high && low_run < min_gap) min_gap = low_run;
      if (chooser_rst) begin had_high = 1'b1; low_run = 0; end
      else low_run++;
      prev_crst = chooser_rst;
      if (done || err) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_unexpected: got done=%b err=%b want none", done, err); end
        else begin
          e = exp_q.pop_front();
          if (err !== e.is_err || done !== !e.is_err || last_sel !== e.sel) begin errors++; $display("FAIL b2b_result: got err=%b last_sel=%0d want err=%b last_sel=%0d", err, last_sel, e.is_err, e.sel); end
        end
        if (done) n_done++;
        if (n_done == 1) begin kick = 1'b1; ksel = 2'd1; end
      end
    end
    start = 1'b0;
    checks++;
    if (n_done != 2) begin errors++; $display("FAIL b2b_dones: got %0d want 2", n_done); end
    checks++;
    if (min_gap < CLR_LOW_MIN || min_gap == 1000) begin errors++; $display("FAIL b2b_crst_gap: got %0d want >=%0d", min_gap, CLR_LOW_MIN); end
    exp_q.delete();
  endtask

  task automatic test_async_reset;
    int got;
    @(posedge clk); #1 start = 1'b1; sel = 2'd2; model_last = 2'd2;
    exp_q.push_back('{is_err: 1'b0, sel: 2'd2});
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (chooser_rst !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL ar_setup: got crst=%b busy=%b want 1 1", chooser_rst, busy); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (chooser_rst !== 1'b0 || busy !== 1'b0 || reqs !== '0) begin errors++; $display("FAIL ar_drop: got crst=%b busy=%b reqs=%b want 0 0 000", chooser_rst, busy, reqs); end
    checks++;
    if (last_sel !== '0) begin errors++; $display("FAIL ar_last_sel: got %0d want 0", last_sel); end
    exp_q.delete(); model_last = '0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 start = 1'b1; sel = 2'd1; model_last = 2'd1;
    exp_q.push_back('{is_err: 1'b0, sel: 2'd1});
    @(posedge clk); #1 start = 1'b0;
    got = 0;
    for (int k = 0; k < 30 && got == 0; k++) begin
      @(negedge clk);
      if (done || err) begin
        got = 1;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL ar_unexpected: got done=%b err=%b want none", done, err); end
        else begin
          e = exp_q.pop_front();
          if (err !== e.is_err || done !== !e.is_err || last_sel !== e.sel) begin errors++; $display("FAIL ar_result: got err=%b last_sel=%0d want err=%b last_sel=%0d", err, last_sel, e.is_err, e.sel); end
        end
      end
    end
    checks++;
    if (got == 0) begin errors++; $display("FAIL ar_timeout: got no completion want done within 30 cycles"); end
  endtask

  initial begin
    test_reset;
    test_normal;
    test_bad_index;
    test_timeout;
    test_busy_ignore;
    test_back_to_back;
    test_async_reset;
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
